fetch_unit: RTL and testbench

Instruction-fetch front end of the pipelined CPU. It owns the program counter, issues addresses to the synchronous instruction memory, and loads the IF/ID pipeline register. It is the consumer of the branch/jump redirect (`should_jump` plus target) that the memory/writeback stage produces. It squashes wrong-path fetches on redirect, holds cleanly under hazard stalls, and keeps saturating fetch and flush counters for debug.

---
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the synchronous instruction
// memory and loads the IF/ID register, with redirect squash, stall hold and debug counters.
module fetch_unit #(
  parameter int              PC_W     = 5,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               should_jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_valid,
  output logic [COUNT_W-1:0] fetch_count,
  output logic [COUNT_W-1:0] flush_count
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc_q;
  logic            req_valid_q;

  logic do_redirect;
  logic do_advance;

  assign do_redirect = should_jump;
  assign do_advance  = !should_jump && !stall;

  // A stall re-reads the pending address so imem_data stays paired with req_pc_q.
  assign imem_addr = (stall && !should_jump) ? req_pc_q : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else if (do_redirect) begin
      pc          <= jump_target;
      req_valid_q <= 1'b0;
    end else if (do_advance) begin
      pc          <= pc + 1'b1;
      req_pc_q    <= pc;
      req_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc    <= '0;
      out_instr <= '0;
      out_valid <= 1'b0;
    end else if (do_redirect) begin
      out_valid <= 1'b0;
    end else if (do_advance) begin
      out_pc    <= req_pc_q;
      out_instr <= imem_data;
      out_valid <= req_valid_q;
    end
  end

  // Debug counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (do_redirect && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
      if (do_advance && req_valid_q && (fetch_count != '1))
        fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle-level reference model feeding a
// scoreboard queue, plus directed checks of the key timing points.
module tb_fetch_unit;

  localparam int              PC_W     = 5;
  localparam int              INSTR_W  = 32;
  localparam int              COUNT_W  = 16;
  localparam int              SAT_W    = 4;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam logic [31:0]     TAG_BITS = 32'hA000_0000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               stall = 1'b0;
  logic               should_jump = 1'b0;
  logic [PC_W-1:0]    jump_target = '0;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_valid;
  logic [COUNT_W-1:0] fetch_count;
  logic [COUNT_W-1:0] flush_count;

  logic [PC_W-1:0]    sat_imem_addr;
  logic [INSTR_W-1:0] sat_imem_data;
  logic [PC_W-1:0]    sat_out_pc;
  logic [INSTR_W-1:0] sat_out_instr;
  logic               sat_out_valid;
  logic [SAT_W-1:0]   sat_fetch_count;
  logic [SAT_W-1:0]   sat_flush_count;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .should_jump(should_jump),
    .jump_target(jump_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_pc(out_pc), .out_instr(out_instr), .out_valid(out_valid),
    .fetch_count(fetch_count), .flush_count(flush_count)
  );

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC), .COUNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .should_jump(should_jump),
    .jump_target(jump_target), .imem_addr(sat_imem_addr), .imem_data(sat_imem_data),
    .out_pc(sat_out_pc), .out_instr(sat_out_instr), .out_valid(sat_out_valid),
    .fetch_count(sat_fetch_count), .flush_count(sat_flush_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address a is 0xA000_0000 | a.
  always @(posedge clk) begin
    imem_data     <= TAG_BITS | 32'(imem_addr);
    sat_imem_data <= TAG_BITS | 32'(sat_imem_addr);
  end

  typedef struct {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    int              fetches;
    int              flushes;
  } exp_t;

  exp_t sb[$];

  logic [PC_W-1:0] m_pc, m_req_pc, m_out_pc;
  logic            m_req_valid, m_out_valid;
  logic [31:0]     m_data, m_out_instr;
  int              m_fetch, m_flush;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int value, input int width);
    int top;
    top = (1 << width) - 1;
    return (value > top) ? 32'(top) : 32'(value);
  endfunction

  task automatic modelReset();
    m_pc = RESET_PC;  m_req_pc = RESET_PC;  m_req_valid = 1'b0;
    m_out_pc = '0;    m_out_instr = '0;     m_out_valid = 1'b0;
    m_fetch = 0;      m_flush = 0;
    m_data = TAG_BITS | 32'(RESET_PC);
  endtask

  // One model edge with redirect > stall > advance priority; returns issued address.
  task automatic modelStep(output logic [PC_W-1:0] addr);
    addr = (stall && !should_jump) ? m_req_pc : m_pc;
    if (should_jump) begin
      m_pc = jump_target;
      m_req_valid = 1'b0;
      m_out_valid = 1'b0;
      m_flush++;
    end else if (!stall) begin
      m_out_instr = m_data;
      m_out_pc    = m_req_pc;
      m_out_valid = m_req_valid;
      if (m_req_valid) m_fetch++;
      m_req_pc    = m_pc;
      m_req_valid = 1'b1;
      m_pc        = m_pc + 1'b1;
    end
    m_data = TAG_BITS | 32'(addr);
  endtask

  // Drive one cycle from a negedge, run it through the model, then compare at the next negedge.
  task automatic applyStimulus(input logic s, input logic j, input logic [PC_W-1:0] tgt);
    logic [PC_W-1:0] addr;
    exp_t e;
    stall = s;
    should_jump = j;
    jump_target = tgt;
    #1;
    modelStep(addr);
    checkOutput("imem_addr", 32'(imem_addr), 32'(addr));
    e.valid = m_out_valid;  e.pc = m_out_pc;  e.instr = m_out_instr;
    e.fetches = m_fetch;    e.flushes = m_flush;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("out_valid", 32'(out_valid), 32'(e.valid));
      checkOutput("out_pc", 32'(out_pc), 32'(e.pc));
      checkOutput("out_instr", out_instr, e.instr);
      checkOutput("fetch_count", 32'(fetch_count), sat(e.fetches, COUNT_W));
      checkOutput("flush_count", 32'(flush_count), sat(e.flushes, COUNT_W));
      checkOutput("sat_fetch_count", 32'(sat_fetch_count), sat(e.fetches, SAT_W));
      checkOutput("sat_flush_count", 32'(sat_flush_count), sat(e.flushes, SAT_W));
      checkOutput("sat_out_pc", 32'(sat_out_pc), 32'(e.pc));
    end
  endtask

  task automatic runFree(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0);
  endtask

  // Free-run from reset release: bubble, bubble-free start at cycle 2, incrementing PCs.
  task automatic startupSequence(input string tag);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput({tag, "_cycle1_valid"}, 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput({tag, "_cycle2_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_cycle2_pc"}, 32'(out_pc), 32'(RESET_PC));
    checkOutput({tag, "_cycle2_instr"}, out_instr, 32'hA000_0000);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput({tag, "_run_pc"}, 32'(out_pc), 32'(k));
    end
    checkOutput({tag, "_fetch_count"}, 32'(fetch_count), 32'd4);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_imem_addr", 32'(imem_addr), 32'(RESET_PC));
    checkOutput("reset_fetch_count", 32'(fetch_count), 32'd0);
    rst_n = 1'b1;

    startupSequence("start");
    runFree(1);
    checkOutput("pre_stall_pc", 32'(out_pc), 32'd4);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("stall_hold_pc", 32'(out_pc), 32'd4);
      checkOutput("stall_imem_addr", 32'(imem_addr), 32'd5);
    end
    for (int k = 5; k <= 7; k++) begin
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("post_stall_pc", 32'(out_pc), 32'(k));
    end

    applyStimulus(1'b0, 1'b1, 5'h12);
    checkOutput("jump_bubble1", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("jump_bubble2", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("jump_target_pc", 32'(out_pc), 32'h12);
    checkOutput("jump_target_instr", out_instr, 32'hA000_0012);
    checkOutput("jump_flush_count", 32'(flush_count), 32'd1);

    applyStimulus(1'b1, 1'b1, 5'h03);
    checkOutput("jump_stall_bubble", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("stall_frozen_bubble", 32'(out_valid), 32'd0);
    runFree(2);
    checkOutput("jump_stall_target", 32'(out_pc), 32'h03);
    runFree(2);

    applyStimulus(1'b0, 1'b1, 5'h08);
    applyStimulus(1'b0, 1'b1, 5'h0A);
    runFree(2);
    checkOutput("b2b_last_target", 32'(out_pc), 32'h0A);
    checkOutput("b2b_flush_count", 32'(flush_count), 32'd4);

    applyStimulus(1'b0, 1'b1, 5'h1E);
    runFree(2);
    begin
      logic [PC_W-1:0] wrap_seq [4];
      wrap_seq = '{5'h1E, 5'h1F, 5'h00, 5'h01};
      for (int k = 0; k < 4; k++) begin
        checkOutput("wrap_pc", 32'(out_pc), 32'(wrap_seq[k]));
        checkOutput("wrap_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, '0);
      end
    end
    runFree(4);
    checkOutput("sat_fetch_stuck", 32'(sat_fetch_count), 32'hF);

    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_imem_addr", 32'(imem_addr), 32'(RESET_PC));
    checkOutput("midreset_fetch_count", 32'(fetch_count), 32'd0);
    checkOutput("midreset_flush_count", 32'(flush_count), 32'd0);
    modelReset();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    startupSequence("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
